// File: rtl/conv_systolic_engine.sv
// KxK signed convolution engine: line-buffered sliding window, parallel
// multiply, adder-tree sum, requantise/saturate, ready/valid result port.
module conv_systolic_engine #(
  parameter int K      = 3,
  parameter int IN_DIM = 4,
  parameter int DW     = 8,
  parameter int AW     = 20,
  parameter int OW     = 8,
  parameter int SHIFT  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          keep_w,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] w_data,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [DW-1:0] d_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [OW-1:0] o_data,
  output logic          o_sat,
  output logic          busy,
  output logic          done
);
  localparam int KK  = K * K;
  localparam int LB  = (K > 1) ? K - 1 : 1;
  localparam int CW  = $clog2(IN_DIM + 1);
  localparam int WCW = $clog2(KK + 1);
  localparam logic signed [AW-1:0] OMAX = AW'(2 ** (OW - 1) - 1);
  localparam logic signed [AW-1:0] OMIN = AW'(-(2 ** (OW - 1)));

  typedef enum logic [2:0] {
    IDLE, LOAD_W, STREAM, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;
  logic w_loaded_q, w_loaded_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic signed [DW-1:0] w_q [KK];
  logic signed [DW-1:0] w_d [KK];
  logic signed [DW-1:0] win_q [KK];
  logic signed [DW-1:0] win_d [KK];
  logic signed [DW-1:0] lb_q [LB][IN_DIM];
  logic signed [DW-1:0] lb_d [LB][IN_DIM];
  logic signed [DW-1:0] col_v [K];
  logic signed [2*DW-1:0] prod_q [KK];
  logic signed [2*DW-1:0] prod_d [KK];
  logic p_vld_q, p_vld_d;
  logic o_valid_q, o_valid_d, o_sat_q, o_sat_d;
  logic [OW-1:0] o_data_q, o_data_d;
  logic en, w_acc, d_acc, last_w, last_px, win_ok;
  logic signed [AW-1:0] acc, sh;

  always_comb begin
    en      = !(o_valid_q && !o_ready);
    w_acc   = (state_q == LOAD_W) && w_valid;
    d_acc   = (state_q == STREAM) && en && d_valid;
    last_w  = wcnt_q == WCW'(KK - 1);
    last_px = (row_q == CW'(IN_DIM - 1)) && (col_q == CW'(IN_DIM - 1));
    win_ok  = (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));

    w_d        = w_q;
    wcnt_d     = wcnt_q;
    w_loaded_d = w_loaded_q;
    if (w_acc) begin
      for (int k = 0; k < KK; k++)
        if (wcnt_q == WCW'(k)) w_d[k] = w_data;
      wcnt_d = last_w ? '0 : wcnt_q + 1'b1;
      if (last_w) w_loaded_d = 1'b1;
    end

    // Column entering the window: older rows from line buffers, newest live.
    for (int i = 0; i < K; i++) col_v[i] = '0;
    col_v[K-1] = d_data;
    for (int i = 0; i < K - 1; i++)
      for (int c = 0; c < IN_DIM; c++)
        if (col_q == CW'(c)) col_v[i] = lb_q[i][c];

    lb_d  = lb_q;
    win_d = win_q;
    col_d = col_q;
    row_d = row_q;
    if (d_acc) begin
      for (int i = 0; i < K - 1; i++)
        for (int c = 0; c < IN_DIM; c++)
          if (col_q == CW'(c)) lb_d[i][c] = col_v[i+1];
      for (int k = 0; k < KK - 1; k++) win_d[k] = win_q[k+1];
      for (int i = 0; i < K; i++) win_d[i*K+K-1] = col_v[i];
      if (col_q == CW'(IN_DIM - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(IN_DIM - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    p_vld_d = p_vld_q;
    prod_d  = prod_q;
    if (en) begin
      p_vld_d = d_acc && win_ok;
      for (int k = 0; k < KK; k++)
        prod_d[k] = (2*DW)'(w_q[k]) * (2*DW)'(win_d[k]);
    end

    acc = '0;
    for (int k = 0; k < KK; k++) acc = acc + AW'(prod_q[k]);
    sh = acc >>> SHIFT;

    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_sat_d   = o_sat_q;
    if (en) begin
      o_valid_d = p_vld_q;
      if (p_vld_q) begin
        o_sat_d  = 1'b1;
        if (sh > OMAX)      o_data_d = OMAX[OW-1:0];
        else if (sh < OMIN) o_data_d = OMIN[OW-1:0];
        else begin
          o_data_d = sh[OW-1:0];
          o_sat_d  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (keep_w && w_loaded_q) ? STREAM : LOAD_W;
      LOAD_W:  if (w_acc && last_w) state_d = STREAM;
      STREAM:  if (d_acc && last_px) state_d = DRAIN;
      DRAIN:   if (o_valid_q && o_ready && !p_vld_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_loaded_q <= 1'b0;
      wcnt_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      w_q        <= '{default: '0};
      win_q      <= '{default: '0};
      lb_q       <= '{default: '{default: '0}};
      prod_q     <= '{default: '0};
      p_vld_q    <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_sat_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_loaded_q <= w_loaded_d;
      wcnt_q     <= wcnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      w_q        <= w_d;
      win_q      <= win_d;
      lb_q       <= lb_d;
      prod_q     <= prod_d;
      p_vld_q    <= p_vld_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_sat_q    <= o_sat_d;
    end
  end

  assign w_ready = state_q == LOAD_W;
  assign d_ready = (state_q == STREAM) && en;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sat   = o_sat_q;

endmodule
